// File: rtl/uart_tx_word_fifo.sv
// Word-wide transmit queue feeding the 32-bit UART word transmitter.
// Buffers reply words and launches one transfer per word, in push order, while the transmitter is idle.
module uart_tx_word_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [31:0]      push_data,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             tx_start,
  output logic [31:0]      tx_word,
  input  logic             tx_idle
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, GUARD, WAIT_DONE} state_t;

  state_t           state;
  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_ok, pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop     = (state == IDLE) & ~empty & tx_idle & ~flush;

  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= push_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_start <= 1'b0;
      tx_word  <= '0;
      state    <= IDLE;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      // A flushed push is discarded silently, so it never flags overflow.
      if (push && full && !flush) overflow <= 1'b1;

      if (flush) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else if (push_ok && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push_ok && pop) begin
        count <= count - CNT_W'(1);
      end

      case (state)
        IDLE: begin
          tx_start <= 1'b0;
          if (pop) begin
            tx_start <= 1'b1;
            tx_word  <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + PTR_W'(1);
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_start <= 1'b0;
          state    <= GUARD;
        end
        // Transmitter idle may still read high right after the start pulse.
        GUARD:     state <= WAIT_DONE;
        WAIT_DONE: if (tx_idle) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_word_fifo.sv
// Randomized bench for uart_tx_word_fifo against a queue-based model of the launch protocol.
module tb_uart_tx_word_fifo;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk, rst, push, flush, tx_idle;
  logic [31:0]      push_data;
  logic             full, empty, overflow, tx_start;
  logic [CNT_W-1:0] count;
  logic [31:0]      tx_word;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_word_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .flush(flush),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_start(tx_start), .tx_word(tx_word), .tx_idle(tx_idle)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: queue of pending words plus "transmitter busy" bookkeeping.
  logic [31:0] q[$];
  bit          m_busy, m_ovf, m_start, chk_en;
  int          m_age;
  logic [31:0] m_word;

  always @(posedge clk) begin
    bit launch, was_full;
    if (rst) begin
      q.delete();
      m_busy = 0; m_ovf = 0; m_start = 0; m_word = '0; m_age = 0;
      chk_en = 1;
    end else if (chk_en) begin
      was_full = (q.size() == DEPTH);
      launch   = !m_busy && q.size() > 0 && tx_idle && !flush;
      if (m_busy) begin
        m_age++;
        // start pulse cycle and guard cycle pass before idle is honoured
        if (m_age >= 3 && tx_idle) m_busy = 0;
      end
      m_start = launch;
      if (launch) begin
        m_word = q.pop_front();
        m_busy = 1;
        m_age  = 0;
      end
      if (flush) q.delete();
      else if (push) begin
        if (was_full) m_ovf = 1;
        else q.push_back(push_data);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",    32'(count),    32'(q.size()));
      chk("full",     32'(full),     32'(q.size() == DEPTH));
      chk("empty",    32'(empty),    32'(q.size() == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("tx_start", 32'(tx_start), 32'(m_start));
      chk("tx_word",  tx_word,       m_word);
    end
  end

  // Transmitter stand-in: 0 random idle, 1 busy for hold_len cycles after each start, 2 stalled.
  int mode = 2, hold_len = 5, hold = 0;
  always @(negedge clk) begin
    case (mode)
      0: tx_idle = ($urandom % 3) != 0;
      1: begin
        if (tx_start) hold = hold_len;
        if (hold > 0) begin tx_idle = 0; hold--; end
        else tx_idle = 1;
      end
      default: tx_idle = 0;
    endcase
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_push(input logic [31:0] d);
    push = 1; push_data = d;
    tick();
    push = 0;
  endtask

  initial begin
    rst = 1; push = 0; flush = 0; push_data = '0; tx_idle = 0;
    tick(2);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_word",  tx_word,    32'd0);
    rst = 0;

    // single word, idle transmitter
    mode = 1; hold_len = 5;
    tick(2);
    do_push(32'hDEADBEEF);
    tick(12);
    chk("single_drained", 32'(count), 32'd0);

    // burst with a long transmitter busy time
    hold_len = 40;
    for (int i = 1; i <= 5; i++) do_push(32'(i));
    tick(5 * 46 + 10);

    // fill past capacity with the transmitter stalled
    mode = 2;
    tick(3);
    for (int i = 0; i < 17; i++) do_push(32'h1000 + 32'(i));
    chk("full_after_17", 32'(full),     32'd1);
    chk("ovf_sticky",    32'(overflow), 32'd1);
    tick(5);
    chk("ovf_still",     32'(overflow), 32'd1);
    mode = 1; hold_len = 3;
    tick(16 * 8 + 20);

    // concurrent push/pop with pointer wrap
    mode = 2;
    tick(3);
    for (int i = 0; i < 3; i++) do_push(32'h2000 + 32'(i));
    mode = 1; hold_len = 2;
    for (int i = 3; i < 40; i++) begin
      push = 1; push_data = 32'h2000 + 32'(i);
      tick();
      push = 0;
      tick($urandom_range(0, 4));
    end
    tick(40 * 8);

    // flush while a word is in flight
    hold_len = 30;
    do_push(32'hA0A0A0A0);
    tick(6);
    for (int i = 0; i < 4; i++) do_push(32'hB000 + 32'(i));
    push = 1; push_data = 32'hCCCC; flush = 1;
    tick();
    push = 0; flush = 0;
    chk("flush_count", 32'(count), 32'd0);
    tick(50);

    // reset mid-stream
    hold_len = 10;
    for (int i = 0; i < 6; i++) do_push(32'h3000 + 32'(i));
    tick(8);
    rst = 1;
    tick(2);
    rst = 0;
    chk("rst_count", 32'(count),    32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    tick(30);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      if (c % 200 == 0) begin
        mode = $urandom % 2;
        hold_len = $urandom_range(0, 12);
      end
      push      = ($urandom % 2) != 0;
      push_data = $urandom;
      flush     = ($urandom % 60) == 0;
      rst       = ($urandom % 400) == 0;
      tick();
    end
    push = 0; flush = 0; rst = 0;
    mode = 1; hold_len = 1;
    tick(DEPTH * 6 + 20);
    chk("final_empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_word_fifo.md
Name: uart_tx_word_fifo

Overview:
Word-wide transmit buffer that sits directly upstream of the 32-bit UART word transmitter in the debugger's response path. Command handlers push 32-bit reply words at core speed. The block queues them and launches one transmitter transfer per word, in order, while the transmitter reports idle. This decouples bursty replies (e.g. memory dumps) from the slow serial line.

Parameters:
DEPTH, 16, number of 32-bit entries; must be a power of two and at least 2.
CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; do not override).

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
push  input  1  enqueue push_data this cycle
push_data  input  32  word to enqueue
flush  input  1  discard all queued (not yet launched) words
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  CNT_W  queued words; excludes the word in flight
overflow  output  1  sticky; set when a push is dropped
tx_start  output  1  one-cycle start pulse to the word transmitter
tx_word  output  32  word presented to the transmitter; valid while tx_start = 1
tx_idle  input  1  transmitter idle level (high = available)

Behaviour:
- Storage: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits. Both pointers wrap naturally at DEPTH. Occupancy is tracked in count, not derived from the pointers.
- Reset (rst = 1): at the next edge, ptrs = 0, count = 0, overflow = 0, tx_start = 0, tx_word = 0, state = IDLE. full = 0 and empty = 1 as a result. Memory contents are don't-care. Reset overrides push and flush.
- full and empty are combinational from the registered count.
- Push: accepted when push = 1 and full = 0 (registered value). On accept, mem[wr_ptr] <= push_data and wr_ptr++.
- Push while full: the word is dropped and overflow <= 1. This holds even if a pop happens in the same cycle. overflow clears only on rst.
- Launch FSM states: IDLE, LAUNCH, GUARD, WAIT_DONE.
  - IDLE: when count != 0, tx_idle = 1 and flush = 0, go to LAUNCH next cycle. In that same edge, register tx_start <= 1 and tx_word <= mem[rd_ptr] (pop), then rd_ptr++.
  - LAUNCH: tx_start is high for exactly this one cycle, with tx_word stable. Go to GUARD. tx_start <= 0.
  - GUARD: one cycle; tx_idle is ignored because the transmitter's idle may still read high. Go to WAIT_DONE.
  - WAIT_DONE: stay until tx_idle = 1, then go to IDLE.
  - Back-to-back words: the next start can issue at the earliest one cycle after the IDLE re-entry.
- tx_word holds the last launched value until the next pop.
- count update per cycle: +1 on accepted push, -1 on pop, unchanged when both occur. Push and pop in the same cycle on a non-full FIFO are both legal. A pop on empty is impossible by construction.
- Latency: push at edge N into an empty FIFO with tx_idle high gives count = 1 after N and tx_start high in the cycle after edge N+1, i.e. 2 cycles.
- Flush:
  - Sets count <= 0 and rd_ptr <= wr_ptr.
  - A push in the same cycle as flush is also discarded; overflow is not set.
  - It does not abort the FSM: a word already in LAUNCH/GUARD/WAIT_DONE completes.
  - It does not suppress a tx_start already registered.
  - Flush blocks a new launch from IDLE that cycle.
- Ordering: words leave strictly in push order.
- Big-endian byte order is the transmitter's responsibility; this block passes words unmodified.

Test Plan:
- Reset: assert rst 2 cycles mid-stream -> after the edge, count = 0, empty = 1, full = 0, overflow = 0, tx_start = 0, tx_word = 0; no tx_start until a new push.
- Single word: push 0xDEADBEEF with tx_idle = 1 -> tx_start high for exactly 1 cycle, 2 cycles after the push edge, with tx_word = 0xDEADBEEF; count returns to 0.
- Burst ordering: push 0x00000001..0x00000005 back-to-back, with a transmitter model holding tx_idle low 40 cycles starting 1 cycle after each start -> five starts in order 1..5. No start is issued while tx_idle = 0 or in the GUARD cycle.
- Full/overflow (DEPTH = 16, tx_idle held 0): push 17 words -> full = 1 after 16, 17th dropped, overflow = 1 and sticky. Release tx_idle -> exactly 16 words sent, first value pushed first.
- Simultaneous push/pop: count = 3, push during the IDLE->LAUNCH pop edge -> count stays 3, ordering preserved; pointer wrap exercised by 40 total words with DEPTH = 16.
- Flush: queue 4 words while word A is in WAIT_DONE, assert flush with a concurrent push -> A completes, no further tx_start, count = 0, overflow = 0.
